// File: rtl/cr_osf_ob_rd_ctl_pkg.sv
// Shared types and constants for the OSF output-buffer read path.
// Imported by the skid buffer and the read controller.
package cr_osfPKG;
  localparam int OSF_DATA_W = 64;
  localparam int OSF_OB_SKID_DEPTH = 2;

  typedef struct packed {
    logic                  eof;
    logic [OSF_DATA_W-1:0] data;
  } osf_ob_word_t;
endpackage

// File: rtl/cr_osf_ob_skid.sv
// Two-entry valid/ready skid buffer that absorbs the FIFO read latency.
// Words are stored as {eof, data}; the head is shown combinationally.
module cr_osf_ob_skid
  import cr_osfPKG::*;
#(
  parameter int DATA_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [DATA_W:0] wr_word,
  input  logic            rd_ready,
  output logic            rd_valid,
  output logic [DATA_W:0] rd_word,
  output logic [1:0]      cnt
);
  logic [DATA_W:0] mem [OSF_OB_SKID_DEPTH];
  logic            head;
  logic            tail;
  logic            rd_fire;

  assign rd_valid = cnt != 2'd0;
  assign rd_fire  = rd_valid && rd_ready;
  // When empty, keep showing the most recently accepted word.
  assign rd_word  = rd_valid ? mem[head] : mem[~head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= 1'b0;
      tail <= 1'b0;
      cnt  <= 2'd0;
      for (int i = 0; i < OSF_OB_SKID_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[tail] <= wr_word;
        tail      <= ~tail;
      end
      if (rd_fire)
        head <= ~head;
      unique case ({wr_en, rd_fire})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/cr_osf_ob_rd_ctl.sv
// OSF output FIFO read controller: credit-based pops, skid buffer,
// single-step read permission and saturating statistics counters.
module cr_osf_ob_rd_ctl
  import cr_osfPKG::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty_mod,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_reof,
  output logic              ob_rd_ok,
  output logic              ob_out_valid,
  output logic [DATA_W-1:0] ob_out_data,
  output logic              ob_out_eof,
  input  logic              ob_out_ready,
  input  logic              ss_step_req,
  output logic              single_step_rd,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stat_words,
  output logic [CNT_W-1:0]  stat_frames,
  output logic [CNT_W-1:0]  stat_stall
);
  logic            inflight;
  logic            ss_pending;
  logic [1:0]      skid_cnt;
  logic [DATA_W:0] head_word;
  logic            acc;
  logic [2:0]      ev;

  // Credit counts words in the skid plus the one returning this cycle.
  assign ob_rd_ok = !fifo_empty_mod &&
    (({1'b0, skid_cnt} + {2'b00, inflight}) < 3'd2);

  cr_osf_ob_skid #(.DATA_W(DATA_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (inflight),
    .wr_word  ({fifo_reof, fifo_rdata}),
    .rd_ready (ob_out_ready),
    .rd_valid (ob_out_valid),
    .rd_word  (head_word),
    .cnt      (skid_cnt)
  );

  assign ob_out_eof     = head_word[DATA_W];
  assign ob_out_data    = head_word[DATA_W-1:0];
  assign single_step_rd = ss_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight   <= 1'b0;
      ss_pending <= 1'b0;
    end else begin
      inflight <= ob_rd_ok;
      if (ss_step_req)
        ss_pending <= 1'b1;
      else if (ob_rd_ok)
        ss_pending <= 1'b0;
    end
  end

  assign acc = ob_out_valid && ob_out_ready;
  assign ev  = {ob_out_valid && !ob_out_ready, acc && ob_out_eof, acc};

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt_q <= '0;
      else if (stat_clr)
        cnt_q <= '0;
      else if (ev[i] && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stat_words  = g_cnt[0].cnt_q;
  assign stat_frames = g_cnt[1].cnt_q;
  assign stat_stall  = g_cnt[2].cnt_q;
endmodule

// File: tb/tb_cr_osf_ob_rd_ctl.sv
// Bench for cr_osf_ob_rd_ctl: queue-based FIFO and delivery model,
// randomized data and backpressure, per-feature scenario tasks.
module tb_cr_osf_ob_rd_ctl;
  import cr_osfPKG::*;

  localparam int DW = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty_mod = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_reof = 1'b0;
  logic          ob_rd_ok;
  logic          ob_out_valid;
  logic [DW-1:0] ob_out_data;
  logic          ob_out_eof;
  logic          ob_out_ready = 1'b0;
  logic          ss_step_req = 1'b0;
  logic          single_step_rd;
  logic          stat_clr = 1'b0;
  logic [CW-1:0] stat_words;
  logic [CW-1:0] stat_frames;
  logic [CW-1:0] stat_stall;

  always #5 clk = ~clk;

  cr_osf_ob_rd_ctl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty_mod (fifo_empty_mod),
    .fifo_rdata     (fifo_rdata),
    .fifo_reof      (fifo_reof),
    .ob_rd_ok       (ob_rd_ok),
    .ob_out_valid   (ob_out_valid),
    .ob_out_data    (ob_out_data),
    .ob_out_eof     (ob_out_eof),
    .ob_out_ready   (ob_out_ready),
    .ss_step_req    (ss_step_req),
    .single_step_rd (single_step_rd),
    .stat_clr       (stat_clr),
    .stat_words     (stat_words),
    .stat_frames    (stat_frames),
    .stat_stall     (stat_stall)
  );

  typedef struct {
    osf_ob_word_t w;
    int           cyc;
  } ent_t;

  osf_ob_word_t src_q[$];
  ent_t         exp_q[$];
  int           cyc, checks, failures;
  longint       words_m, frames_m, stall_m;
  bit           ss_m, ss_mode, pend;
  osf_ob_word_t pend_w;
  int           dut_pops, dut_valids, dmax_cnt;
  bit           dut_rdok, dut_valid, dut_ss;

  // A popped word is presented two cycles after its pop, in pop order.
  function automatic bit mvalid();
    return exp_q.size() > 0 && exp_q[0].cyc <= cyc - 2;
  endfunction

  function automatic longint sat(input longint v);
    return (v < 64'h0000_0000_FFFF_FFFF) ? v + 1 : v;
  endfunction

  function automatic osf_ob_word_t rnd_word(input bit eof);
    osf_ob_word_t w;
    w.data = {$urandom, $urandom};
    w.eof  = eof;
    return w;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pend = 0;
    words_m = 0; frames_m = 0; stall_m = 0;
    ss_m = 0;
  endtask

  task automatic step(input bit rdy, input bit req, input bit clr);
    bit ev, acc, exp_rd;
    osf_ob_word_t w;
    @(negedge clk);
    if (pend) begin
      fifo_rdata = pend_w.data;
      fifo_reof  = pend_w.eof;
    end
    pend = 0;
    ob_out_ready   = rdy;
    ss_step_req    = req;
    stat_clr       = clr;
    fifo_empty_mod = (src_q.size() == 0) || (ss_mode && !ss_m);
    #1;
    ev     = mvalid();
    exp_rd = !fifo_empty_mod && exp_q.size() < 2;
    checks++;
    if (ob_out_valid !== ev) begin
      failures++;
      $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, ob_out_valid, ev);
    end
    if (ev) begin
      checks++;
      if (ob_out_data !== exp_q[0].w.data || ob_out_eof !== exp_q[0].w.eof) begin
        failures++;
        $display("FAIL word cyc=%0d got=%h/%b exp=%h/%b", cyc, ob_out_data,
                 ob_out_eof, exp_q[0].w.data, exp_q[0].w.eof);
      end
    end
    checks++;
    if (ob_rd_ok !== exp_rd) begin
      failures++;
      $display("FAIL rd_ok cyc=%0d got=%b exp=%b", cyc, ob_rd_ok, exp_rd);
    end
    checks++;
    if (single_step_rd !== ss_m) begin
      failures++;
      $display("FAIL ss_rd cyc=%0d got=%b exp=%b", cyc, single_step_rd, ss_m);
    end
    checks++;
    if (stat_words !== words_m[31:0] || stat_frames !== frames_m[31:0] ||
        stat_stall !== stall_m[31:0]) begin
      failures++;
      $display("FAIL stats cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, stat_words,
               stat_frames, stat_stall, words_m[31:0], frames_m[31:0], stall_m[31:0]);
    end
    dut_rdok  = ob_rd_ok;
    dut_valid = ob_out_valid;
    dut_ss    = single_step_rd;
    if (ob_rd_ok === 1'b1) dut_pops++;
    if (ob_out_valid === 1'b1) dut_valids++;
    if (int'(dut.skid_cnt) > dmax_cnt) dmax_cnt = int'(dut.skid_cnt);
    acc = ev && rdy;
    if (clr) begin
      words_m = 0; frames_m = 0; stall_m = 0;
    end else begin
      if (acc) words_m = sat(words_m);
      if (acc && exp_q[0].w.eof) frames_m = sat(frames_m);
      if (ev && !rdy) stall_m = sat(stall_m);
    end
    if (acc) void'(exp_q.pop_front());
    if (exp_rd) begin
      w = src_q.pop_front();
      exp_q.push_back('{w, cyc});
      pend   = 1;
      pend_w = w;
    end
    ss_m = req ? 1'b1 : (exp_rd ? 1'b0 : ss_m);
    cyc++;
    @(posedge clk);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    ss_mode = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < bound) begin
      step(1, 0, 0);
      n++;
    end
    checks++;
    if (src_q.size() > 0 || exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout got=%0d left exp=0", src_q.size() + exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (ob_out_valid !== 1'b0 || ob_rd_ok !== 1'b0 || single_step_rd !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b%b%b exp=000", ob_out_valid, ob_rd_ok, single_step_rd);
    end
    checks++;
    if (ob_out_data !== '0 || ob_out_eof !== 1'b0) begin
      failures++;
      $display("FAIL reset_data got=%h/%b exp=0/0", ob_out_data, ob_out_eof);
    end
    checks++;
    if (stat_words !== '0 || stat_frames !== '0 || stat_stall !== '0) begin
      failures++;
      $display("FAIL reset_stats got=%h/%h/%h exp=0", stat_words, stat_frames, stat_stall);
    end
    rst = 1'b0;
    model_reset();
    @(posedge clk);
  endtask

  task automatic test_stream();
    int start, first_v;
    for (int i = 0; i < 8; i++) src_q.push_back(rnd_word(i == 7));
    dut_pops = 0; dut_valids = 0;
    start = cyc; first_v = -1;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      if (dut_valid && first_v < 0) first_v = cyc - 1 - start;
    end
    checks++;
    if (dut_pops != 8 || dut_valids != 8) begin
      failures++;
      $display("FAIL stream_counts got=%0d/%0d exp=8/8", dut_pops, dut_valids);
    end
    checks++;
    if (first_v != 2) begin
      failures++;
      $display("FAIL stream_latency got=%0d exp=2", first_v);
    end
    checks++;
    if (stat_words !== 32'd8 || stat_frames !== 32'd1 || stat_stall !== 32'd0) begin
      failures++;
      $display("FAIL stream_stats got=%0d/%0d/%0d exp=8/1/0", stat_words, stat_frames, stat_stall);
    end
  endtask

  task automatic test_backpressure();
    int late_pops = 0;
    step(1, 0, 1);
    for (int i = 0; i < 8; i++) src_q.push_back(rnd_word(i == 7));
    dmax_cnt = 0;
    for (int i = 0; i < 26; i++) begin
      step(!(i >= 3 && i <= 10), 0, 0);
      if (i >= 5 && i <= 10 && dut_rdok) late_pops++;
    end
    checks++;
    if (dmax_cnt != 2) begin
      failures++;
      $display("FAIL bp_skid_max got=%0d exp=2", dmax_cnt);
    end
    checks++;
    if (late_pops != 0) begin
      failures++;
      $display("FAIL bp_pops_stalled got=%0d exp=0", late_pops);
    end
    checks++;
    if (stat_stall !== 32'd8 || stat_words !== 32'd8) begin
      failures++;
      $display("FAIL bp_stats got=%0d/%0d exp=8/8", stat_stall, stat_words);
    end
    drain(20);
  endtask

  task automatic test_single_step();
    int p0;
    ss_mode = 1;
    for (int i = 0; i < 3; i++) src_q.push_back(rnd_word(1'b0));
    dut_pops = 0;
    step(1, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    checks++;
    if (dut_pops != 1 || single_step_rd !== 1'b0) begin
      failures++;
      $display("FAIL ss_one_pop got=%0d/%b exp=1/0", dut_pops, single_step_rd);
    end
    drain(30);
    for (int i = 0; i < 2; i++) src_q.push_back(rnd_word(1'b0));
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    for (int i = 0; i < 3; i++) src_q.push_back(rnd_word(1'b0));
    ss_mode = 1;
    p0 = dut_pops;
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    checks++;
    if (dut_pops - p0 != 1) begin
      failures++;
      $display("FAIL ss_no_queue got=%0d exp=1", dut_pops - p0);
    end
    drain(30);
  endtask

  task automatic test_simultaneous();
    ss_mode = 1;
    for (int i = 0; i < 4; i++) src_q.push_back(rnd_word(1'b0));
    dut_pops = 0;
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    checks++;
    if (dut_ss !== 1'b1) begin
      failures++;
      $display("FAIL simul_pending got=%b exp=1", dut_ss);
    end
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    checks++;
    if (dut_pops != 2) begin
      failures++;
      $display("FAIL simul_pops got=%0d exp=2", dut_pops);
    end
    drain(30);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) src_q.push_back(rnd_word(1'b1));
    step(0, 0, 0);
    step(0, 0, 0);
    @(negedge clk);
    fifo_rdata = pend_w.data;
    fifo_reof  = pend_w.eof;
    fifo_empty_mod = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (ob_out_valid !== 1'b0 || single_step_rd !== 1'b0 || ob_out_data !== '0 ||
        ob_out_eof !== 1'b0) begin
      failures++;
      $display("FAIL midrst_out got=%b%b%h%b exp=0", ob_out_valid, single_step_rd,
               ob_out_data, ob_out_eof);
    end
    checks++;
    if (stat_words !== '0 || stat_frames !== '0 || stat_stall !== '0) begin
      failures++;
      $display("FAIL midrst_stats got=%h/%h/%h exp=0", stat_words, stat_frames, stat_stall);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    dut_valids = 0;
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    checks++;
    if (dut_valids != 0) begin
      failures++;
      $display("FAIL midrst_drop got=%0d exp=0", dut_valids);
    end
  endtask

  task automatic test_random();
    int n = 0;
    for (int i = 0; i < 40; i++) src_q.push_back(rnd_word($urandom_range(3) == 0));
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < 600) begin
      step($urandom_range(3) != 0, 0, 0);
      n++;
    end
    checks++;
    if (src_q.size() > 0 || exp_q.size() > 0) begin
      failures++;
      $display("FAIL random_timeout got=%0d exp=0", src_q.size() + exp_q.size());
    end
  endtask

  task automatic test_saturation();
    bit v;
    #1 force dut.g_cnt[0].cnt_q = 32'hFFFF_FFFD;
    #1 release dut.g_cnt[0].cnt_q;
    words_m = 64'h0000_0000_FFFF_FFFD;
    for (int i = 0; i < 3; i++) src_q.push_back(rnd_word(1'b0));
    drain(20);
    step(1, 0, 0);
    checks++;
    if (stat_words !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL sat_hold got=%h exp=ffffffff", stat_words);
    end
    src_q.push_back(rnd_word(1'b1));
    for (int i = 0; i < 10; i++) begin
      v = mvalid();
      step(1, 0, v);
      if (v) break;
    end
    step(1, 0, 0);
    checks++;
    if (stat_words !== '0 || stat_frames !== '0 || stat_stall !== '0) begin
      failures++;
      $display("FAIL clr_prio got=%h/%h/%h exp=0", stat_words, stat_frames, stat_stall);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    ss_mode = 0; dut_pops = 0; dut_valids = 0; dmax_cnt = 0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_single_step();
    test_simultaneous();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
